// File: rtl/regbus_byte_bridge_pkg.sv
// Shared opcode, status and state definitions for the byte-stream register-bus bridge.
package regbus_byte_bridge_pkg;

  localparam logic [7:0] OP_RD    = 8'h01;
  localparam logic [7:0] OP_WR    = 8'h02;

  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_ERR   = 8'h01;
  localparam logic [7:0] ST_TMO   = 8'h02;
  localparam logic [7:0] ST_BADOP = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/regbus_byte_bridge.sv
// Byte-stream command decoder that issues one register-bus transaction per frame
// and streams a status byte (plus read data on a good read) back to the host.
module regbus_byte_bridge
  import regbus_byte_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        regreq,
  output logic        regwr,
  output logic [15:0] regaddr,
  output logic [31:0] regwdata,
  input  logic        regack,
  input  logic        regerr,
  input  logic [31:0] regrdata,
  output logic        busy
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         last_q, last_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [31:0]        sh_q, sh_d;
  logic [31:0]        regwdata_q, regwdata_d;
  logic [15:0]        regaddr_q, regaddr_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               regwr_q, regwr_d;
  logic               regreq_q, regreq_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               rx_ready_c, rx_fire_c, tx_fire_c;

  // Host may push bytes only while a frame is being collected, never during reset.
  assign rx_ready_c = !rst && (state_q inside {S_IDLE, S_ADDR, S_DATA});
  assign rx_fire_c  = rx_valid && rx_ready_c;
  assign tx_fire_c  = tx_valid_q && tx_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    tmr_d      = tmr_q;
    sh_d       = sh_q;
    regwdata_d = regwdata_q;
    regaddr_d  = regaddr_q;
    tx_data_d  = tx_data_q;
    regwr_d    = regwr_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      S_IDLE: begin
        if (rx_fire_c) begin
          cnt_d = 3'd0;
          if (rx_data == OP_RD || rx_data == OP_WR) begin
            regwr_d = (rx_data == OP_WR);
            state_d = S_ADDR;
          end else begin
            tx_data_d  = ST_BADOP;
            last_d     = 3'd0;
            tx_valid_d = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire_c) begin
          regaddr_d = {regaddr_q[7:0], rx_data};
          cnt_d     = cnt_q + 3'd1;
          if (cnt_q == 3'd1) begin
            cnt_d   = 3'd0;
            state_d = regwr_q ? S_DATA : S_REQ;
          end
        end
      end
      S_DATA: begin
        if (rx_fire_c) begin
          regwdata_d = {regwdata_q[23:0], rx_data};
          cnt_d      = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // Timer counts cycles since the strobe; the strobe cycle itself is 0.
        tmr_d   = TMR_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (regack) begin
          tx_data_d  = regerr ? ST_ERR : ST_OK;
          sh_d       = regrdata;
          last_d     = (!regerr && !regwr_q) ? 3'd4 : 3'd0;
          cnt_d      = 3'd0;
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          tx_data_d  = ST_TMO;
          last_d     = 3'd0;
          cnt_d      = 3'd0;
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (tx_fire_c) begin
          if (cnt_q == last_q) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_data_d = sh_q[31:24];
            sh_d      = {sh_q[23:0], 8'h00};
            cnt_d     = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    regreq_d = (state_d == S_REQ);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      last_q     <= 3'd0;
      tmr_q      <= '0;
      sh_q       <= 32'h0;
      regwdata_q <= 32'h0;
      regaddr_q  <= 16'h0;
      tx_data_q  <= 8'h00;
      regwr_q    <= 1'b0;
      regreq_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      tmr_q      <= tmr_d;
      sh_q       <= sh_d;
      regwdata_q <= regwdata_d;
      regaddr_q  <= regaddr_d;
      tx_data_q  <= tx_data_d;
      regwr_q    <= regwr_d;
      regreq_q   <= regreq_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_ready = rx_ready_c;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign regreq   = regreq_q;
  assign regwr    = regwr_q;
  assign regaddr  = regaddr_q;
  assign regwdata = regwdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regbus_byte_bridge.sv
// Randomized self-checking bench for regbus_byte_bridge against a frame-level response model.
module tb_regbus_byte_bridge;
  import regbus_byte_bridge_pkg::*;

  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        regreq;
  logic        regwr;
  logic [15:0] regaddr;
  logic [31:0] regwdata;
  logic        regack;
  logic        regerr;
  logic [31:0] regrdata;
  logic        busy;

  regbus_byte_bridge #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .regreq(regreq), .regwr(regwr), .regaddr(regaddr), .regwdata(regwdata),
    .regack(regack), .regerr(regerr), .regrdata(regrdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk, n_fail;

  // Observed traffic
  logic [7:0]  txq[$];
  int          txr_cyc[$];
  logic [15:0] rq_addr[$];
  logic        rq_wr[$];
  logic [31:0] rq_wd[$];
  int          rq_cyc[$];
  int          stab_viol, long_req, rx_viol;
  logic        pv, pr, preq, wflag;
  logic [7:0]  pd;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0; pr = 1'b0; preq = 1'b0; wflag = 1'b0; pd = 8'h00;
    end else begin
      if (tx_valid && !pv) txr_cyc.push_back(cyc);
      if (pv && !pr && (!tx_valid || tx_data !== pd)) stab_viol++;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (regreq) begin
        if (preq) long_req++;
        else begin
          rq_addr.push_back(regaddr); rq_wr.push_back(regwr);
          rq_wd.push_back(regwdata);  rq_cyc.push_back(cyc);
        end
        wflag = 1'b1;
      end
      if (tx_valid) wflag = 1'b0;
      if (rx_ready && (regreq || wflag || tx_valid)) rx_viol++;
      pv = tx_valid; pr = tx_ready; pd = tx_data; preq = regreq;
    end
  end

  // Host tx_ready: 0 random, 1 ten-cycle stalls per byte, 2 always ready
  int bp_mode, bp_cnt;
  always @(posedge clk) begin
    #1;
    if (bp_mode == 1) begin
      bp_cnt++;
      tx_ready = (bp_cnt % 11 == 0);
    end else if (bp_mode == 2) tx_ready = 1'b1;
    else tx_ready = ($urandom_range(0, 3) != 0);
  end

  // Slave: acks s_delay cycles after regreq when enabled; late_req injects a stray ack
  logic        s_en, s_err;
  int          s_delay, ack_cnt, ack_cyc, late_req, late_done;
  logic [31:0] s_rdata;
  logic        ack_pend;
  always @(negedge clk) begin
    regack = 1'b0; regerr = 1'b0; regrdata = 32'h0;
    if (rst) ack_pend = 1'b0;
    else if (ack_pend) begin
      if (ack_cnt <= 1) begin
        regack = 1'b1; regerr = s_err; regrdata = s_rdata;
        ack_pend = 1'b0; ack_cyc = cyc;
      end else ack_cnt--;
    end else if (late_req != late_done) begin
      regack = 1'b1; regerr = 1'b1; regrdata = 32'hFFFF_FFFF;
      late_done++;
    end
    if (!rst && regreq && s_en) begin ack_pend = 1'b1; ack_cnt = s_delay; end
  end

  int tx_base, rq_base, txr_base, last_rx_cyc;
  logic [7:0] exp_q[$];

  task automatic mark();
    tx_base = txq.size(); rq_base = rq_cyc.size(); txr_base = txr_cyc.size();
  endtask

  // Reference: response is fixed by opcode, whether the ack beats the timeout, and regerr.
  task automatic model(input logic [7:0] op, input logic en, input int dly,
                       input logic err, input logic [31:0] rd);
    exp_q.delete();
    if (op != OP_RD && op != OP_WR) exp_q.push_back(ST_BADOP);
    else if (!en || dly > TMO - 1) exp_q.push_back(ST_TMO);
    else if (err) exp_q.push_back(ST_ERR);
    else begin
      exp_q.push_back(ST_OK);
      if (op == OP_RD) for (int i = 3; i >= 0; i--) exp_q.push_back(rd[i*8 +: 8]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int wd;
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    wd = 0;
    while (!rx_ready && wd < 1000) begin @(negedge clk); wd++; end
    if (wd >= 1000) begin
      n_chk++; n_fail++;
      $display("FAIL rx_accept_timeout: got rx_ready=%b want 1", rx_ready);
    end
    last_rx_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [15:0] a,
                           input logic [31:0] wd, input int nresp);
    int w;
    send_byte(op);
    if (op == OP_RD || op == OP_WR) begin
      send_byte(a[15:8]); send_byte(a[7:0]);
      if (op == OP_WR) for (int i = 3; i >= 0; i--) send_byte(wd[i*8 +: 8]);
    end
    w = 0;
    while (!((txq.size() >= tx_base + nresp) && !busy) && w < 3000) begin
      @(negedge clk); w++;
    end
    if (w >= 3000) begin
      n_chk++; n_fail++;
      $display("FAIL frame_timeout: got %0d bytes want %0d", txq.size() - tx_base, nresp);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; bp_mode = 2;
    s_en = 1'b1; s_delay = 3; s_err = 1'b0; s_rdata = 32'h0;
    repeat (3) @(negedge clk);
    n_chk++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    n_chk++; if (regreq !== 1'b0) begin n_fail++; $display("FAIL rst_regreq: got %b want 0", regreq); end
    n_chk++; if (regwr !== 1'b0) begin n_fail++; $display("FAIL rst_regwr: got %b want 0", regwr); end
    n_chk++; if (regaddr !== 16'h0) begin n_fail++; $display("FAIL rst_regaddr: got %h want 0000", regaddr); end
    n_chk++; if (regwdata !== 32'h0) begin n_fail++; $display("FAIL rst_regwdata: got %h want 0", regwdata); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_rx_ready: got %b want 1", rx_ready); end
  endtask

  task automatic test_read();
    s_en = 1'b1; s_delay = 3; s_err = 1'b0; s_rdata = 32'h0000_0010; bp_mode = 2;
    mark(); model(OP_RD, 1'b1, 3, 1'b0, 32'h10);
    run_frame(OP_RD, 16'h0004, 32'h0, 5);
    n_chk++; if (txq.size() - tx_base !== exp_q.size()) begin n_fail++; $display("FAIL read_len: got %0d want %0d", txq.size() - tx_base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && tx_base + i < txq.size(); i++) begin
      n_chk++; if (txq[tx_base+i] !== exp_q[i]) begin n_fail++; $display("FAIL read_byte%0d: got %h want %h", i, txq[tx_base+i], exp_q[i]); end
    end
    n_chk++; if (rq_cyc.size() - rq_base !== 1) begin n_fail++; $display("FAIL read_reqcnt: got %0d want 1", rq_cyc.size() - rq_base); end
    n_chk++; if (rq_addr[rq_base] !== 16'h0004) begin n_fail++; $display("FAIL read_addr: got %h want 0004", rq_addr[rq_base]); end
    n_chk++; if (rq_wr[rq_base] !== 1'b0) begin n_fail++; $display("FAIL read_wr: got %b want 0", rq_wr[rq_base]); end
    n_chk++; if (long_req !== 0) begin n_fail++; $display("FAIL read_req_width: got %0d long strobes want 0", long_req); end
    n_chk++; if (rq_cyc[rq_base] !== last_rx_cyc + 1) begin n_fail++; $display("FAIL read_req_latency: got %0d want %0d", rq_cyc[rq_base], last_rx_cyc + 1); end
    n_chk++; if (txr_cyc[txr_base] !== ack_cyc + 1) begin n_fail++; $display("FAIL read_ack_latency: got %0d want %0d", txr_cyc[txr_base], ack_cyc + 1); end
  endtask

  task automatic test_write();
    s_en = 1'b1; s_delay = 2; s_err = 1'b0; s_rdata = 32'h1234_5678; bp_mode = 2;
    mark(); model(OP_WR, 1'b1, 2, 1'b0, 32'h0);
    run_frame(OP_WR, 16'h0000, 32'hDEAD_BEEF, 1);
    n_chk++; if (txq.size() - tx_base !== 1) begin n_fail++; $display("FAIL write_len: got %0d want 1", txq.size() - tx_base); end
    n_chk++; if (txq[tx_base] !== exp_q[0]) begin n_fail++; $display("FAIL write_status: got %h want %h", txq[tx_base], exp_q[0]); end
    n_chk++; if (rq_wd[rq_base] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_wdata: got %h want deadbeef", rq_wd[rq_base]); end
    n_chk++; if (rq_wr[rq_base] !== 1'b1) begin n_fail++; $display("FAIL write_wr: got %b want 1", rq_wr[rq_base]); end
    n_chk++; if (rq_cyc[rq_base] !== last_rx_cyc + 1) begin n_fail++; $display("FAIL write_req_latency: got %0d want %0d", rq_cyc[rq_base], last_rx_cyc + 1); end
  endtask

  task automatic test_error_badop();
    s_en = 1'b1; s_delay = 4; s_err = 1'b1; s_rdata = 32'h0; bp_mode = 0;
    mark(); model(OP_WR, 1'b1, 4, 1'b1, 32'h0);
    run_frame(OP_WR, 16'h0010, 32'h0BAD_F00D, 1);
    n_chk++; if (txq[tx_base] !== exp_q[0] || txq.size() - tx_base !== 1) begin n_fail++; $display("FAIL err_status: got %h want %h", txq[tx_base], exp_q[0]); end
    n_chk++; if (rq_addr[rq_base] !== 16'h0010) begin n_fail++; $display("FAIL err_addr: got %h want 0010", rq_addr[rq_base]); end
    mark(); model(8'h7F, 1'b1, 4, 1'b0, 32'h0);
    run_frame(8'h7F, 16'h0, 32'h0, 1);
    n_chk++; if (txq[tx_base] !== exp_q[0] || txq.size() - tx_base !== 1) begin n_fail++; $display("FAIL badop_status: got %h want %h", txq[tx_base], exp_q[0]); end
    n_chk++; if (rq_cyc.size() !== rq_base) begin n_fail++; $display("FAIL badop_noreq: got %0d strobes want 0", rq_cyc.size() - rq_base); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    int n;
    s_en = 1'b0; bp_mode = 2;
    mark(); model(OP_RD, 1'b0, 0, 1'b0, 32'h0);
    run_frame(OP_RD, 16'($urandom), 32'h0, 1);
    n_chk++; if (txq[tx_base] !== exp_q[0] || txq.size() - tx_base !== 1) begin n_fail++; $display("FAIL tmo_status: got %h want %h", txq[tx_base], exp_q[0]); end
    n_chk++; if (txr_cyc[txr_base] - rq_cyc[rq_base] !== TMO) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", txr_cyc[txr_base] - rq_cyc[rq_base], TMO); end
    n = txq.size();
    late_req++;
    repeat (6) @(negedge clk);
    n_chk++; if (txq.size() !== n || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_late_ack: got %0d bytes busy=%b want 0 bytes busy=0", txq.size() - n, busy); end
    // Ack landing exactly on the terminal count must beat the timeout
    for (int k = 0; k < 2; k++) begin
      rd = $urandom; s_en = 1'b1; s_delay = TMO - 1; s_err = k[0]; s_rdata = rd;
      mark(); model(OP_RD, 1'b1, TMO - 1, k[0], rd);
      run_frame(OP_RD, 16'($urandom), 32'h0, exp_q.size());
      n_chk++; if (txq.size() - tx_base !== exp_q.size()) begin n_fail++; $display("FAIL tmo_edge_len%0d: got %0d want %0d", k, txq.size() - tx_base, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && tx_base + i < txq.size(); i++) begin
        n_chk++; if (txq[tx_base+i] !== exp_q[i]) begin n_fail++; $display("FAIL tmo_edge%0d_byte%0d: got %h want %h", k, i, txq[tx_base+i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    int w;
    rd = $urandom; s_en = 1'b1; s_delay = 5; s_err = 1'b0; s_rdata = rd; bp_mode = 1;
    mark(); model(OP_RD, 1'b1, 5, 1'b0, rd);
    fork
      run_frame(OP_RD, 16'h1234, 32'h0, 5);
      begin
        w = 0;
        while (rq_cyc.size() == rq_base && w < 2000) begin @(negedge clk); w++; end
        @(negedge clk);
        rx_data = OP_RD; rx_valid = 1'b1;
        w = 0;
        while (txq.size() == tx_base && w < 2000) begin @(negedge clk); w++; end
        rx_valid = 1'b0;
      end
    join
    n_chk++; if (txq.size() - tx_base !== 5) begin n_fail++; $display("FAIL bp_len: got %0d want 5", txq.size() - tx_base); end
    for (int i = 0; i < exp_q.size() && tx_base + i < txq.size(); i++) begin
      n_chk++; if (txq[tx_base+i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h want %h", i, txq[tx_base+i], exp_q[i]); end
    end
    n_chk++; if (stab_viol !== 0) begin n_fail++; $display("FAIL bp_tx_stable: got %0d changes want 0", stab_viol); end
    n_chk++; if (rx_viol !== 0) begin n_fail++; $display("FAIL bp_rx_ready: got %0d ready cycles want 0", rx_viol); end
    n_chk++; if (rq_cyc.size() - rq_base !== 1) begin n_fail++; $display("FAIL bp_reqcnt: got %0d want 1", rq_cyc.size() - rq_base); end
  endtask

  task automatic test_rst_mid_frame();
    logic [31:0] rd;
    bp_mode = 2; s_en = 1'b1; s_delay = 2; s_err = 1'b0;
    mark();
    send_byte(OP_WR); send_byte(8'h00); send_byte(8'h0C); send_byte(8'hAA);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got busy=%b rx_ready=%b want 0 0", busy, rx_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (rx_ready !== 1'b1 || rq_cyc.size() !== rq_base) begin n_fail++; $display("FAIL rst_mid_idle: got rx_ready=%b strobes=%0d want 1 0", rx_ready, rq_cyc.size() - rq_base); end
    rd = $urandom; s_rdata = rd;
    mark(); model(OP_RD, 1'b1, 2, 1'b0, rd);
    run_frame(OP_RD, 16'h0020, 32'h0, 5);
    n_chk++; if (rq_cyc.size() - rq_base !== 1 || rq_wr[rq_base] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got cnt=%0d wr=%b want 1 0", rq_cyc.size() - rq_base, rq_wr[rq_base]); end
    n_chk++; if (rq_addr[rq_base] !== 16'h0020) begin n_fail++; $display("FAIL rst_mid_addr: got %h want 0020", rq_addr[rq_base]); end
    for (int i = 0; i < exp_q.size() && tx_base + i < txq.size(); i++) begin
      n_chk++; if (txq[tx_base+i] !== exp_q[i]) begin n_fail++; $display("FAIL rst_mid_byte%0d: got %h want %h", i, txq[tx_base+i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  op;
    logic [15:0] a;
    logic [31:0] wd, rd;
    int sel, d;
    bp_mode = 0;
    for (int it = 0; it < 25; it++) begin
      sel = $urandom_range(0, 9);
      op = (sel < 5) ? OP_RD : (sel < 9) ? OP_WR : 8'($urandom_range(3, 255));
      a = 16'($urandom); wd = $urandom; rd = $urandom; d = $urandom_range(1, 20);
      s_en = 1'b1; s_delay = d; s_err = 1'($urandom_range(0, 1)); s_rdata = rd;
      mark(); model(op, 1'b1, d, s_err, rd);
      run_frame(op, a, wd, exp_q.size());
      n_chk++; if (txq.size() - tx_base !== exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_len: got %0d want %0d", it, txq.size() - tx_base, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && tx_base + i < txq.size(); i++) begin
        n_chk++; if (txq[tx_base+i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_byte%0d: got %h want %h", it, i, txq[tx_base+i], exp_q[i]); end
      end
      n_chk++;
      if (op != OP_RD && op != OP_WR) begin
        if (rq_cyc.size() !== rq_base) begin n_fail++; $display("FAIL rnd%0d_badop_req: got %0d want 0", it, rq_cyc.size() - rq_base); end
      end else if (rq_cyc.size() - rq_base !== 1 || rq_addr[rq_base] !== a || rq_wr[rq_base] !== (op == OP_WR) ||
                   (op == OP_WR && rq_wd[rq_base] !== wd)) begin
        n_fail++;
        $display("FAIL rnd%0d_req: got cnt=%0d addr=%h wr=%b wd=%h want 1 %h %b %h", it, rq_cyc.size() - rq_base,
                 rq_addr[rq_base], rq_wr[rq_base], rq_wd[rq_base], a, op == OP_WR, wd);
      end
    end
    n_chk++; if (long_req !== 0 || stab_viol !== 0 || rx_viol !== 0) begin n_fail++; $display("FAIL rnd_protocol: got long=%0d stab=%0d rx=%0d want 0 0 0", long_req, stab_viol, rx_viol); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_error_badop();
    test_timeout();
    test_backpressure();
    test_rst_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
